key_move_ctrl: RTL and testbench



---
 rtl/key_move_ctrl.sv | 115 +++++++++++
 tb/tb_key_move_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_move_ctrl.sv
// Turns A/D make/break events into a held-direction level plus a rate-limited step strobe.
// Last-pressed key wins; a held key steps once, waits HOLD_DELAY, then repeats every REPEAT_PERIOD.
module key_move_ctrl #(
    parameter logic [8:0]  KEY_A         = 9'h01C,
    parameter logic [8:0]  KEY_D         = 9'h023,
    parameter int unsigned HOLD_DELAY    = 2000000,
    parameter int unsigned REPEAT_PERIOD = 524288,
    parameter int unsigned CNT_W         = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         key_valid,
    input  logic [8:0]   last_change,
    input  logic [511:0] key_down,
    output logic [1:0]   key_state,
    output logic         move_pulse,
    output logic         repeating
);

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_REPEAT} state_e;
    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_e;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       key_state_q, key_state_d;
    logic             move_pulse_q, move_pulse_d;
    logic             repeating_q, repeating_d;

    logic       is_ad, make_ev, break_ev, other_held, strobe;
    dir_e       ev_dir;
    logic [8:0] other_code;

    assign is_ad      = (last_change == KEY_A) || (last_change == KEY_D);
    assign make_ev    = key_valid && is_ad && key_down[last_change];
    assign break_ev   = key_valid && is_ad && !key_down[last_change];
    assign ev_dir     = (last_change == KEY_A) ? DIR_LEFT : DIR_RIGHT;
    assign other_code = (dir_q == DIR_LEFT) ? KEY_D : KEY_A;
    assign other_held = key_down[other_code];

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q + CNT_W'(1);
        strobe  = 1'b0;

        if (!enable) begin
            state_d = S_IDLE;
            timer_d = '0;
        end else if (state_q == S_IDLE) begin
            timer_d = '0;
            if (make_ev) begin
                state_d = S_PRESS;
                dir_d   = ev_dir;
                strobe  = 1'b1;
            end
        end else if (make_ev && ev_dir != dir_q) begin
            state_d = S_PRESS;
            dir_d   = ev_dir;
            timer_d = '0;
            strobe  = 1'b1;
        end else if (break_ev && ev_dir == dir_q) begin
            timer_d = '0;
            if (other_held) begin
                state_d = S_PRESS;
                dir_d   = (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
                strobe  = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end else if (state_q == S_PRESS && timer_q == HOLD_LAST) begin
            state_d = S_REPEAT;
            timer_d = '0;
            strobe  = 1'b1;
        end else if (state_q == S_REPEAT && timer_q == REPEAT_LAST) begin
            timer_d = '0;
            strobe  = 1'b1;
        end

        // Back-to-back events must not produce a two-cycle-wide strobe.
        move_pulse_d = strobe && !move_pulse_q;
        repeating_d  = (state_d == S_REPEAT);
        if (state_d == S_IDLE) key_state_d = 2'b00;
        else                   key_state_d = (dir_d == DIR_LEFT) ? 2'b10 : 2'b01;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            dir_q        <= DIR_LEFT;
            timer_q      <= '0;
            key_state_q  <= 2'b00;
            move_pulse_q <= 1'b0;
            repeating_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            timer_q      <= timer_d;
            key_state_q  <= key_state_d;
            move_pulse_q <= move_pulse_d;
            repeating_q  <= repeating_d;
        end
    end

    assign key_state  = key_state_q;
    assign move_pulse = move_pulse_q;
    assign repeating  = repeating_q;

endmodule

// File: tb/tb_key_move_ctrl.sv
// Scoreboard bench for key_move_ctrl: a cycle-count reference model predicts outputs each edge,
// a monitor compares them; directed scenarios then randomized key traffic.
module tb_key_move_ctrl;

    localparam int HD = 10;
    localparam int RP = 4;
    localparam logic [8:0] KA = 9'h01C;
    localparam logic [8:0] KD = 9'h023;
    localparam logic [8:0] KX = 9'h029;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic [1:0]   key_state;
    logic         move_pulse;
    logic         repeating;

    key_move_ctrl #(
        .KEY_A(KA), .KEY_D(KD), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP), .CNT_W(24)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .key_valid(key_valid),
        .last_change(last_change), .key_down(key_down),
        .key_state(key_state), .move_pulse(move_pulse), .repeating(repeating)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ks;
        logic       mp;
        logic       rep;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulse_cnt = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: active key (0 none, 1 A, 2 D) and the cycle of its last event strobe.
    int m_act, m_anchor, m_n;
    logic m_prev;
    initial begin
        m_act = 0; m_anchor = 0; m_n = 0; m_prev = 1'b0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_act = 0; m_anchor = 0; m_n = 0; m_prev = 1'b0;
                exp_q.delete();
            end else begin
                int   ev_key, el;
                logic want;
                exp_t e;
                m_n++;
                want = 1'b0;
                ev_key = (last_change == KA) ? 1 : (last_change == KD) ? 2 : 0;
                if (!enable) begin
                    m_act = 0;
                end else if (key_valid && ev_key != 0 && key_down[last_change] && ev_key != m_act) begin
                    m_act = ev_key; m_anchor = m_n; want = 1'b1;
                end else if (key_valid && ev_key != 0 && !key_down[last_change] && ev_key == m_act) begin
                    if (key_down[(m_act == 1) ? KD : KA]) begin
                        m_act = 3 - m_act; m_anchor = m_n; want = 1'b1;
                    end else begin
                        m_act = 0;
                    end
                end else if (m_act != 0) begin
                    el = m_n - m_anchor;
                    if (el == HD || (el > HD && (el - HD) % RP == 0)) want = 1'b1;
                end
                el    = m_n - m_anchor;
                e.mp  = want && !m_prev;
                m_prev = e.mp;
                e.rep = (m_act != 0) && (el >= HD);
                e.ks  = (m_act == 1) ? 2'b10 : (m_act == 2) ? 2'b01 : 2'b00;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: samples 2 time units after each rising edge.
    logic prev_mp = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("key_state", int'(key_state), int'(e.ks));
                check("move_pulse", int'(move_pulse), int'(e.mp));
                check("repeating", int'(repeating), int'(e.rep));
                check("no_double_pulse", int'(move_pulse & prev_mp), 0);
            end
            if (move_pulse) pulse_cnt++;
            prev_mp = move_pulse;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            key_valid = 1'b0;
        end
    endtask

    task automatic ev(input logic [8:0] code, input logic down);
        @(negedge clk);
        key_down[code] = down;
        last_change    = code;
        key_valid      = 1'b1;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; key_valid = 1'b0; last_change = '0; key_down = '0;
        tick(3);
        check("reset_key_state", int'(key_state), 0);
        check("reset_move_pulse", int'(move_pulse), 0);
        check("reset_repeating", int'(repeating), 0);
        rst = 1'b1;
        tick(2);

        // Tap A: single step, no repeat.
        pulse_cnt = 0;
        ev(KA, 1'b1); tick(4); ev(KA, 1'b0); tick(14);
        check("tap_pulses", pulse_cnt, 1);
        check("tap_release_state", int'(key_state), 0);

        // Hold D: steps at +1, +11, +15, +19, +23, +27.
        pulse_cnt = 0;
        ev(KD, 1'b1); tick(29);
        check("hold_pulses", pulse_cnt, 6);
        check("hold_repeating", int'(repeating), 1);
        check("hold_state", int'(key_state), 1);

        // Asynchronous reset while repeating.
        #2 rst = 1'b0;
        #1;
        check("async_rst_state", int'(key_state), 0);
        check("async_rst_pulse", int'(move_pulse), 0);
        check("async_rst_rep", int'(repeating), 0);
        tick(2);
        rst = 1'b1;
        pulse_cnt = 0;
        tick(12);
        check("post_rst_pulses", pulse_cnt, 0);
        check("post_rst_state", int'(key_state), 0);
        ev(KD, 1'b0); tick(2);

        // Overlap: hold A, D pressed, D released, A released.
        ev(KA, 1'b1); tick(5);
        ev(KD, 1'b1); tick(1);
        check("overlap_d_wins", int'(key_state), 1);
        tick(1);
        ev(KD, 1'b0); tick(1);
        check("overlap_back_to_a", int'(key_state), 2);
        ev(KA, 1'b0); tick(1);
        check("overlap_release", int'(key_state), 0);
        tick(3);

        // Typematic repeats and a foreign key must not disturb the schedule.
        pulse_cnt = 0;
        ev(KA, 1'b1);
        for (int i = 0; i < 9; i++) begin
            tick(2);
            if (i == 4) ev(KX, 1'b1);
            else        ev(KA, 1'b1);
        end
        tick(1);
        check("typematic_pulses", pulse_cnt, 6);
        ev(KA, 1'b0); ev(KX, 1'b0); tick(3);

        // Enable drop while repeating; held key must not restart motion.
        ev(KA, 1'b1); tick(15);
        enable = 1'b0;
        tick(1);
        check("disable_state", int'(key_state), 0);
        check("disable_pulse", int'(move_pulse), 0);
        check("disable_rep", int'(repeating), 0);
        pulse_cnt = 0;
        tick(3);
        enable = 1'b1;
        tick(15);
        check("reenable_no_motion", pulse_cnt, 0);
        check("reenable_state", int'(key_state), 0);
        ev(KA, 1'b1); tick(1);
        check("reenable_new_make", int'(key_state), 2);
        check("reenable_pulse", pulse_cnt, 1);
        ev(KA, 1'b0); tick(2);

        // Randomized traffic on A, D and a foreign key, with occasional enable drops.
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 20) begin
                logic [8:0] code;
                int k;
                k = int'($urandom_range(0, 4));
                code = (k < 2) ? KA : (k < 4) ? KD : KX;
                ev(code, ($urandom_range(0, 2) != 0) ? ~key_down[code] : key_down[code]);
            end else if (r < 22) begin
                @(negedge clk);
                key_valid = 1'b0;
                enable = ~enable;
            end else begin
                tick(1);
            end
        end
        enable = 1'b1;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
